ice51_uart_loader: RTL and testbench
====================================

// Module: ice51_uart_loader
// PURPOSE
//  UART boot loader that sits upstream of the ice51 code memory (1024x8).
//  Receives a length-prefixed program image on the UART RX line and writes
//  it byte by byte into code memory from address 0. Holds the CPU in reset
//  until the image is complete, then releases it.
// PARAMETERS
//  CLKS_PER_BIT  104   i_clk cycles per UART bit (12 MHz / 115200); min 4
//  ADDR_W        10    code memory address width; DEPTH = 2**ADDR_W
// PORTS
//  i_clk        in   1       system clock, all logic on rising edge
//  i_rst        in   1       asynchronous reset, active-high
//  i_uart_rx    in   1       UART RX, 8N1, idle high, asynchronous to i_clk
//  o_uart_tx    out  1       UART TX (echo path, see CONFIGURATION)
//  o_code_wr    out  1       code memory write strobe, 1-cycle pulse
//  o_code_addr  out  ADDR_W  code memory write address
//  o_code_data  out  8       code memory write data
//  o_cpu_nrst   out  1       CPU reset, low = CPU held in reset
//  o_busy       out  1       high while an image is being loaded
//  o_err        out  1       sticky error flag
// BEHAVIOUR
//  Reset: o_uart_tx=1, o_code_wr=0, o_code_addr=0, o_code_data=0,
//   o_cpu_nrst=0, o_busy=0, o_err=0; FSM=LEN_HI. Reset mid-load aborts the
//   load; no partial state survives.
//  RX: 2-flop synchroniser on i_uart_rx. Falling edge in idle starts a
//   frame; start bit re-checked at CLKS_PER_BIT/2, still low else frame is
//   discarded as a glitch. Data sampled every CLKS_PER_BIT from mid-start,
//   LSB first. Stop bit sampled mid-bit: 1 = byte valid (1-cycle rx_valid),
//   0 = framing error: byte discarded, o_err set, FSM unchanged.
//  Image format: LEN_HI, LEN_LO (16-bit big-endian byte count N), N bytes.
//  FSM:
//   LEN_HI: rx_valid -> latch len[15:8], o_busy=1 -> LEN_LO
//   LEN_LO: rx_valid -> latch len[7:0]; N==0 -> DONE; N>DEPTH -> ERR;
//           else -> DATA with count=N
//   DATA:   each rx_valid -> next cycle o_code_wr=1 with o_code_data=byte,
//           o_code_addr=current addr; addr increments after the strobe;
//           count decrements; write of last byte -> DONE
//   DONE:   o_busy=0, o_cpu_nrst=1 from cycle after the final write strobe
//           (or after LEN_LO when N==0). Further RX bytes ignored, no writes.
//   ERR:    o_err=1, o_busy=0, o_cpu_nrst stays 0; terminal until reset.
//  o_code_addr holds its last value between strobes; after DONE it equals N
//   mod DEPTH (N==DEPTH wraps to 0; no write ever issued beyond DEPTH-1).
//  Write latency: o_code_wr asserts exactly 1 cycle after the stop-bit
//   sample of the byte. At most one write per received byte.
//  o_err is sticky: cleared only by i_rst. Framing errors in DONE still set
//   o_err but do not affect o_cpu_nrst.
// CONFIGURATION
//  ICE51_LOADER_ECHO_EN defined: every valid received byte (length and data,
//   in any state except ERR) is retransmitted on o_uart_tx, 8N1, same
//   CLKS_PER_BIT, TX start bit begins 1 cycle after rx_valid. If the
//   transmitter is busy, that byte is not echoed (no error raised).
//  Not defined: no TX logic; o_uart_tx tied to 1.
// TESTING
//  CLKS_PER_BIT=8 for all scenarios unless noted.
//  1 Send 00 03 A5 5A FF -> writes (0,A5),(1,5A),(2,FF), one strobe each;
//    o_cpu_nrst rises 1 cycle after 3rd strobe; o_err=0; o_code_addr=3.
//  2 Send 00 00 -> no o_code_wr; o_cpu_nrst=1 one cycle after LEN_LO byte.
//  3 Send 04 01 -> FSM ERR, o_err=1, o_cpu_nrst=0, no writes; later bytes ignored.
//  4 Send 00 02 11 then a frame with stop bit 0, then 22 -> o_err=1, writes
//    (0,11),(1,22) only; o_cpu_nrst=1 after 2nd write.
//  5 Assert i_rst mid-DATA after 2 of 4 bytes, then send 00 01 77 -> write
//    (0,77); all outputs at reset values during reset.
//  6 ECHO_EN build: send 00 01 3C with 2-bit gaps -> o_uart_tx carries
//    00 01 3C; non-ECHO build: o_uart_tx constant 1.
//  Also: 1-cycle low glitch on i_uart_rx in idle -> no byte, no o_err.

Source files
------------

// File: rtl/ice51_uart_loader.sv
// UART boot loader for the ice51 code memory: length-prefixed image in, byte writes out.
// Optional echo transmitter enabled by defining ICE51_LOADER_ECHO_EN.
module ice51_uart_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_rx,
    output logic              o_uart_tx,
    output logic              o_code_wr,
    output logic [ADDR_W-1:0] o_code_addr,
    output logic [7:0]        o_code_data,
    output logic              o_cpu_nrst,
    output logic              o_busy,
    output logic              o_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]      DEPTH     = 17'(2 ** ADDR_W);

    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
    localparam logic [2:0] ST_LEN_HI = 3'd0, ST_LEN_LO = 3'd1, ST_DATA = 3'd2,
                           ST_DONE = 3'd3, ST_ERR = 3'd4;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]       rx_st_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_byte_q;
    logic             rx_stop_s, rx_valid_s, rx_ferr_s;

    logic [2:0]        st_q, st_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       cnt_q, cnt_d, len_s;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_q, wr_d, nrst_q, nrst_d, busy_q, busy_d, err_q, err_d;

    // Receiver: synchronise, detect start edge, sample mid-bit, LSB first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= 3'd0;
            rx_byte_q <= 8'd0;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            case (rx_st_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    rx_bit_q <= 3'd0;
                    if (rx_prev_q && !rx_sync_q) rx_st_q <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q  <= '0;
                        rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                        rx_bit_q  <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_st_q  <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_stop_s  = (rx_st_q == RX_STOP) && (rx_cnt_q == BIT_LAST);
    assign rx_valid_s = rx_stop_s && rx_sync_q;
    assign rx_ferr_s  = rx_stop_s && !rx_sync_q;
    assign len_s      = {len_hi_q, rx_byte_q};

    // Loader FSM next state; address advances the cycle after each strobe.
    always_comb begin
        st_d     = st_q;
        len_hi_d = len_hi_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        wr_d     = 1'b0;
        nrst_d   = nrst_q;
        busy_d   = busy_q;
        err_d    = err_q | rx_ferr_s;
        if (wr_q) addr_d = addr_q + ADDR_W'(1);
        else      addr_d = addr_q;
        case (st_q)
            ST_LEN_HI: begin
                if (rx_valid_s) begin
                    len_hi_d = rx_byte_q;
                    busy_d   = 1'b1;
                    st_d     = ST_LEN_LO;
                end else begin
                    st_d = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (!rx_valid_s) begin
                    st_d = ST_LEN_LO;
                end else if (len_s == 16'd0) begin
                    busy_d = 1'b0;
                    nrst_d = 1'b1;
                    st_d   = ST_DONE;
                end else if ({1'b0, len_s} > DEPTH) begin
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                    st_d   = ST_ERR;
                end else begin
                    cnt_d = len_s;
                    st_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid_s) begin
                    wr_d   = 1'b1;
                    data_d = rx_byte_q;
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) st_d = ST_DONE;
                    else                st_d = ST_DATA;
                end else begin
                    st_d = ST_DATA;
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
                nrst_d = 1'b1;
            end
            ST_ERR: begin
                busy_d = 1'b0;
                nrst_d = 1'b0;
                err_d  = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                nrst_d = 1'b0;
                err_d  = 1'b1;
                st_d   = ST_ERR;
            end
        endcase
    end

    // Loader state and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            st_q     <= ST_LEN_HI;
            len_hi_q <= 8'd0;
            cnt_q    <= 16'd0;
            addr_q   <= '0;
            data_q   <= 8'd0;
            wr_q     <= 1'b0;
            nrst_q   <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            len_hi_q <= len_hi_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            nrst_q   <= nrst_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign o_code_wr   = wr_q;
    assign o_code_addr = addr_q;
    assign o_code_data = data_q;
    assign o_cpu_nrst  = nrst_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

`ifdef ICE51_LOADER_ECHO_EN
    logic             tx_q, tx_busy_q, echo_s;
    logic [8:0]       tx_shift_q;
    logic [3:0]       tx_idx_q;
    logic [CNT_W-1:0] tx_cnt_q;

    assign echo_s = rx_valid_s && (st_q != ST_ERR) && !tx_busy_q;

    // Echo transmitter: index 0 is the start bit, 1..8 data, 9 stop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= 9'h1ff;
            tx_idx_q   <= 4'd0;
            tx_cnt_q   <= '0;
        end else if (echo_s) begin
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_shift_q <= {1'b1, rx_byte_q};
            tx_idx_q   <= 4'd0;
            tx_cnt_q   <= '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q <= '0;
                if (tx_idx_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    tx_q       <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    tx_idx_q   <= tx_idx_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_uart_tx = tx_q;
`else
    assign o_uart_tx = 1'b1;
`endif
endmodule

// File: tb/tb_ice51_uart_loader.sv
// Directed bench for ice51_uart_loader at 8 clocks per bit, plus a 4-deep instance for wrap/overflow.
module tb_ice51_uart_loader;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    logic       tx, wr, nrst, busy, err;
    logic [9:0] addr;
    logic [7:0] data;
    logic       tx2, wr2, nrst2, busy2, err2;
    logic [1:0] addr2;
    logic [7:0] data2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_wr_cyc = -1;
    int nrst_rise_cyc = -1;
    logic nrst_prev = 1'b0;
    int tx_low_cnt = 0;

    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    logic [15:0] wa2[$];
    logic [7:0]  wd2[$];
    logic [7:0]  echo_q[$];

    always #5 clk = ~clk;

    ice51_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(10)) dut (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .o_uart_tx(tx),
        .o_code_wr(wr), .o_code_addr(addr), .o_code_data(data),
        .o_cpu_nrst(nrst), .o_busy(busy), .o_err(err)
    );

    ice51_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx), .o_uart_tx(tx2),
        .o_code_wr(wr2), .o_code_addr(addr2), .o_code_data(data2),
        .o_cpu_nrst(nrst2), .o_busy(busy2), .o_err(err2)
    );

    // Write logger and timing monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (wr) begin
            wa.push_back({6'd0, addr});
            wd.push_back(data);
            last_wr_cyc = cyc;
        end
        if (wr2) begin
            wa2.push_back({14'd0, addr2});
            wd2.push_back(data2);
        end
        if (nrst && !nrst_prev) nrst_rise_cyc = cyc;
        nrst_prev = nrst;
        if (!tx) tx_low_cnt = tx_low_cnt + 1;
    end

`ifdef ICE51_LOADER_ECHO_EN
    // Decoder for the echoed frames.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!tx && !rst) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                echo_q.push_back(b);
            end
        end
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input int i, input logic [15:0] a, input logic [7:0] d);
        check($sformatf("wr%0d_present", i), 32'(wa.size() > i), 32'd1);
        if (wa.size() > i) begin
            check($sformatf("wr%0d_addr", i), 32'(wa[i]), 32'(a));
            check($sformatf("wr%0d_data", i), 32'(wd[i]), 32'(d));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_wr_nrst_busy_err", {27'd0, tx, wr, nrst, busy, err}, 32'b10000);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        wa.delete(); wd.delete(); wa2.delete(); wd2.delete(); echo_q.delete();
        last_wr_cyc = -1;
        nrst_rise_cyc = -1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // 1: three-byte image
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hA5, 1'b1);
        check("s1_busy_mid", 32'(busy), 32'd1);
        check("s1_nrst_mid", 32'(nrst), 32'd0);
        send_byte(8'h5A, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (10) @(negedge clk);
        check("s1_wr_count", 32'(wa.size()), 32'd3);
        check_wr(0, 16'd0, 8'hA5);
        check_wr(1, 16'd1, 8'h5A);
        check_wr(2, 16'd2, 8'hFF);
        check("s1_nrst", 32'(nrst), 32'd1);
        check("s1_nrst_lat", 32'(nrst_rise_cyc - last_wr_cyc), 32'd1);
        check("s1_err", 32'(err), 32'd0);
        check("s1_busy", 32'(busy), 32'd0);
        check("s1_addr", 32'(addr), 32'd3);
        send_byte(8'h66, 1'b1);
        check("s1_done_ignores", 32'(wa.size()), 32'd3);

        // 2: empty image
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("s2_wr_count", 32'(wa.size()), 32'd0);
        check("s2_nrst", 32'(nrst), 32'd1);
        check("s2_busy_err", {30'd0, busy, err}, 32'd0);

        // 3: oversize length 0x0401
        do_reset();
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1);
        check("s3_err", 32'(err), 32'd1);
        check("s3_nrst", 32'(nrst), 32'd0);
        check("s3_busy", 32'(busy), 32'd0);
        check("s3_wr_count", 32'(wa.size()), 32'd0);

        // 4: framing error between data bytes
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h99, 1'b0);
        check("s4_err_sticky", 32'(err), 32'd1);
        send_byte(8'h22, 1'b1);
        repeat (4) @(negedge clk);
        check("s4_wr_count", 32'(wa.size()), 32'd2);
        check_wr(0, 16'd0, 8'h11);
        check_wr(1, 16'd1, 8'h22);
        check("s4_nrst", 32'(nrst), 32'd1);
        check("s4_addr", 32'(addr), 32'd2);

        // 5: reset mid-load, then a fresh one-byte image
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        check("s5_busy_before_rst", 32'(busy), 32'd1);
        check("s5_addr_before_rst", 32'(addr), 32'd2);
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h77, 1'b1);
        check("s5_wr_count", 32'(wa.size()), 32'd1);
        check_wr(0, 16'd0, 8'h77);
        check("s5_nrst", 32'(nrst), 32'd1);

        // glitch in idle, then confirm the receiver still works
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        check("gl_busy_err", {30'd0, busy, err}, 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h42, 1'b1);
        check("gl_wr_count", 32'(wa.size()), 32'd1);
        check_wr(0, 16'd0, 8'h42);
        check("gl_err", 32'(err), 32'd0);

        // wrap at full depth on the 4-entry instance
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i * 16), 1'b1);
        check("w_count", 32'(wa2.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (wa2.size() > i) begin
                check($sformatf("w%0d_addr", i), 32'(wa2[i]), 32'(i));
                check($sformatf("w%0d_data", i), 32'(wd2[i]), 32'((i + 1) * 16));
            end
        end
        check("w_addr_wrapped", 32'(addr2), 32'd0);
        check("w_nrst_err", {30'd0, nrst2, err2}, 32'b10);
        check("w_main_addr", 32'(addr), 32'd4);

        // length one past depth on the 4-entry instance
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        check("ov_err_nrst_busy", {29'd0, err2, nrst2, busy2}, 32'b100);
        check("ov_main_busy_err", {30'd0, busy, err}, 32'b10);

        // 6: echo path
        do_reset();
        tx_low_cnt = 0;
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (12 * CPB) @(negedge clk);
        check("s6_wr", 32'(wa.size()), 32'd1);
`ifdef ICE51_LOADER_ECHO_EN
        check("s6_echo_count", 32'(echo_q.size()), 32'd3);
        if (echo_q.size() == 3) begin
            check("s6_echo0", 32'(echo_q[0]), 32'h00);
            check("s6_echo1", 32'(echo_q[1]), 32'h01);
            check("s6_echo2", 32'(echo_q[2]), 32'h3C);
        end
`else
        check("s6_tx_low_cycles", 32'(tx_low_cnt), 32'd0);
        check("s6_tx_idle", 32'(tx), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
